radiant_trig_sched: RTL and testbench

Trigger scheduler sitting in front of the event control core in the sys_clk domain. It arbitrates up to NUM_SRC trigger requesters (software, RF, external, PPS-derived) onto the single event-generation strobe, enforces a programmable holdoff after each event, and throttles on the number of events issued but not yet completed. Its outputs drive the event core's event, type and info inputs. Its done input is the same done strobe that feeds the DMA-request FIFO.

---
 rtl/radiant_trig_sched.sv | 204 ++++++++++++++++++++
 tb/tb_radiant_trig_sched.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/radiant_trig_sched.sv
// radiant_trig_sched
// ------------------
// Trigger scheduler in front of the event control core (sys_clk domain).
// Arbitrates up to NUM_SRC level trigger requesters onto one event strobe,
// enforces a programmable holdoff after each event and throttles on the
// number of events issued but not yet completed.
//
// Optional build macro: RADIANT_TRIG_DEADCOUNT_EN
//   defined   -> 32-bit saturating dropped-edge counter drives dead_count_o
//   undefined -> no counter is built, dead_count_o is tied to 0
//
// Ports
//   clk_i         sys_clk, all logic on the rising edge
//   rst_i         asynchronous active-high reset
//   trig_req_i    level trigger requests, only rising edges count
//   trig_mask_i   1 = source enabled
//   holdoff_i     dead cycles after each event, sampled when an event is taken
//   event_done_i  one-cycle pulse, one issued event finished readout
//   event_o       one-cycle event strobe
//   event_type_o  1 when the winner is source 0 (software/forced)
//   event_info_o  {seq[11:0], coinc[15:0], winner[3:0]}, held until next event
//   busy_o        not idle, or pending count at its maximum
//   pending_o     events issued minus events done
//   dead_count_o  number of cycles in which edges were dropped

module radiant_trig_sched #(
  parameter int NUM_SRC     = 4,
  parameter int MAX_PENDING = 4,
  parameter int HOLDOFF_W   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_SRC-1:0]   trig_req_i,
  input  logic [NUM_SRC-1:0]   trig_mask_i,
  input  logic [HOLDOFF_W-1:0] holdoff_i,
  input  logic                 event_done_i,
  output logic                 event_o,
  output logic                 event_type_o,
  output logic [31:0]          event_info_o,
  output logic                 busy_o,
  output logic [3:0]           pending_o,
  output logic [31:0]          dead_count_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FIRE    = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  localparam logic [3:0] L_MAXP = 4'(MAX_PENDING);
  localparam logic [4:0] L_NSRC = 5'(NUM_SRC);
  localparam logic [3:0] L_LAST = 4'(NUM_SRC - 1);

  state_t               r_state;
  logic [NUM_SRC-1:0]   r_req_q;
  logic [3:0]           r_rr_ptr;
  logic [11:0]          r_seq;
  logic [HOLDOFF_W-1:0] r_hold;
  logic [3:0]           r_pending;
  logic                 r_event;
  logic                 r_type;
  logic [31:0]          r_info;

  logic [NUM_SRC-1:0]   w_edge;
  logic [NUM_SRC-1:0]   w_rot;
  logic [3:0]           w_winner;
  logic                 w_full;
  logic                 w_fire_ok;
  logic [3:0]           w_rr_next;

  // Rising-edge detect on enabled sources only; masked sources are invisible
  // to arbitration, coincidence reporting and drop counting alike.
  assign w_edge    = trig_req_i & ~r_req_q & trig_mask_i;
  assign w_full    = (r_pending == L_MAXP);
  assign w_fire_ok = (r_state == IDLE) && (w_edge != '0) && !w_full;

  // Rotate the edge vector so that bit 0 corresponds to the round-robin
  // pointer; the first set bit of the rotated vector is then the winner.
  assign w_rot = NUM_SRC'({w_edge, w_edge} >> r_rr_ptr);

  // Priority search over the rotated vector, mapping the hit back to a source
  // index with a single conditional wrap (the pointer is always < NUM_SRC).
  always_comb begin
    logic       found;
    logic [4:0] sum;
    found    = 1'b0;
    sum      = '0;
    w_winner = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && w_rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, r_rr_ptr} + 5'(i);
        if (sum >= L_NSRC) begin
          sum = sum - L_NSRC;
        end
        w_winner = sum[3:0];
      end
    end
  end

  // Pointer moves one past the source that just won, wrapping at NUM_SRC.
  assign w_rr_next = (r_info[3:0] == L_LAST) ? 4'd0 : (r_info[3:0] + 4'd1);

  // Previous-cycle copy of the request levels. Cleared by reset so a request
  // held through reset release is seen as a fresh edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_req_q <= '0;
    end else begin
      r_req_q <= trig_req_i;
    end
  end

  // Main scheduler FSM. Event strobe, type and info are registered here so
  // they appear in the FIRE cycle, one cycle after the qualifying edge. The
  // sequence number and round-robin pointer advance during FIRE; the holdoff
  // value latched at acceptance doubles as the holdoff down-counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_event  <= 1'b0;
      r_type   <= 1'b0;
      r_info   <= '0;
      r_seq    <= '0;
      r_rr_ptr <= '0;
      r_hold   <= '0;
    end else begin
      r_event <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_fire_ok) begin
            r_state <= FIRE;
            r_event <= 1'b1;
            r_type  <= (w_winner == 4'd0);
            r_info  <= {r_seq, 16'(w_edge), w_winner};
            r_hold  <= holdoff_i;
          end
        end
        FIRE: begin
          r_seq    <= r_seq + 12'd1;
          r_rr_ptr <= w_rr_next;
          if (r_hold != '0) begin
            r_state <= HOLDOFF;
          end else begin
            r_state <= IDLE;
          end
        end
        HOLDOFF: begin
          if (r_hold == HOLDOFF_W'(1)) begin
            r_state <= IDLE;
          end
          r_hold <= r_hold - HOLDOFF_W'(1);
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Outstanding-event counter. A done pulse with nothing outstanding is
  // ignored; an issue and a completion in the same cycle cancel out. The FSM
  // refuses to fire when full, so the count never exceeds MAX_PENDING.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pending <= '0;
    end else begin
      if (r_event && !(event_done_i && (r_pending != '0))) begin
        r_pending <= r_pending + 4'd1;
      end else if (!r_event && event_done_i && (r_pending != '0)) begin
        r_pending <= r_pending - 4'd1;
      end
    end
  end

`ifdef RADIANT_TRIG_DEADCOUNT_EN
  logic        w_drop;
  logic [31:0] r_dead;

  // A drop is any cycle with a live edge that does not start an event,
  // counted once per cycle however many sources rose. Saturates at all-ones.
  assign w_drop = (w_edge != '0) && !w_fire_ok;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_dead <= '0;
    end else if (w_drop && (r_dead != 32'hFFFF_FFFF)) begin
      r_dead <= r_dead + 32'd1;
    end
  end

  assign dead_count_o = r_dead;
`else
  assign dead_count_o = '0;
`endif

  assign event_o      = r_event;
  assign event_type_o = r_type;
  assign event_info_o = r_info;
  assign pending_o    = r_pending;
  assign busy_o       = (r_state != IDLE) || w_full;

endmodule

// File: tb/tb_radiant_trig_sched.sv
module tb_radiant_trig_sched;

  localparam int NSRC = 4;
  localparam int MAXP = 2;
  localparam int HW   = 16;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [NSRC-1:0] trig_req_i;
  logic [NSRC-1:0] trig_mask_i;
  logic [HW-1:0]   holdoff_i;
  logic            event_done_i;
  logic            event_o;
  logic            event_type_o;
  logic [31:0]     event_info_o;
  logic            busy_o;
  logic [3:0]      pending_o;
  logic [31:0]     dead_count_o;

  radiant_trig_sched #(
    .NUM_SRC(NSRC),
    .MAX_PENDING(MAXP),
    .HOLDOFF_W(HW)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .trig_req_i(trig_req_i),
    .trig_mask_i(trig_mask_i),
    .holdoff_i(holdoff_i),
    .event_done_i(event_done_i),
    .event_o(event_o),
    .event_type_o(event_type_o),
    .event_info_o(event_info_o),
    .busy_o(busy_o),
    .pending_o(pending_o),
    .dead_count_o(dead_count_o)
  );

  // Free-running sys_clk, 10 time units per period.
  always #5 clk_i = ~clk_i;

  int compared   = 0;
  int mismatched = 0;
  int eventsSeen = 0;

  // Reference model, kept in terms of time and counts rather than states:
  // the scheduler is idle from cycle mReady onwards, an accepted edge makes
  // the event visible one cycle later and the scheduler idle again 2+H
  // cycles after the edge.
  logic [NSRC-1:0] mReqQ;
  int              mPending;
  int              mSeq;
  int              mRr;
  int              mReady;
  int              n;
  logic [31:0]     mDead;
  logic [31:0]     mInfo;
  logic            mEvent;
  logic            mType;

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at time %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mReqQ    = '0;
    mPending = 0;
    mSeq     = 0;
    mRr      = 0;
    mReady   = 0;
    mDead    = '0;
    mInfo    = '0;
    mEvent   = 1'b0;
    mType    = 1'b0;
  endtask

  // Compare every output against the model for the current cycle.
  task automatic checkAll();
    logic expBusy;
    expBusy = (n < mReady) || (mPending == MAXP);
    checkOutput("event_o", {31'd0, event_o}, {31'd0, mEvent});
    if (mEvent) begin
      checkOutput("event_type_o", {31'd0, event_type_o}, {31'd0, mType});
      eventsSeen++;
    end
    checkOutput("event_info_o", event_info_o, mInfo);
    checkOutput("busy_o", {31'd0, busy_o}, {31'd0, expBusy});
    checkOutput("pending_o", {28'd0, pending_o}, 32'(mPending));
    checkOutput("dead_count_o", dead_count_o, mDead);
  endtask

  // Drive one cycle of inputs and advance the model by that cycle.
  task automatic applyStimulus(input logic [NSRC-1:0] req, input logic [NSRC-1:0] mask,
                               input logic done, input logic [HW-1:0] hold);
    logic [NSRC-1:0] edges;
    logic            accept;
    int              dec;
    int              w;
    trig_req_i   = req;
    trig_mask_i  = mask;
    event_done_i = done;
    holdoff_i    = hold;

    edges  = req & ~mReqQ & mask;
    accept = (edges != '0) && (n >= mReady) && (mPending < MAXP);
    dec    = (done && mPending > 0) ? 1 : 0;
    mPending = mPending + (mEvent ? 1 : 0) - dec;

    if (accept) begin
      w = -1;
      for (int k = 0; k < NSRC; k++) begin
        if (w < 0 && edges[(mRr + k) % NSRC]) w = (mRr + k) % NSRC;
      end
      mInfo  = {12'(mSeq), 16'(edges), 4'(w)};
      mType  = (w == 0);
      mSeq   = (mSeq + 1) % 4096;
      mRr    = (w + 1) % NSRC;
      mReady = n + 2 + int'(hold);
    end else if (edges != '0) begin
`ifdef RADIANT_TRIG_DEADCOUNT_EN
      if (mDead != 32'hFFFF_FFFF) mDead = mDead + 32'd1;
`endif
    end
    mEvent = accept;
    mReqQ  = req;
    n++;
  endtask

  logic [NSRC-1:0] curMask;

  task automatic applyRandom();
    logic [NSRC-1:0] req;
    logic [HW-1:0]   hold;
    logic            done;
    req  = trig_req_i ^ (NSRC'($urandom_range(0, 15)) & NSRC'($urandom_range(0, 15)));
    done = ($urandom_range(0, 4) == 0);
    hold = ($urandom_range(0, 2) == 0) ? '0 : HW'($urandom_range(0, 6));
    applyStimulus(req, curMask, done, hold);
  endtask

  initial begin
    rst_i        = 1'b1;
    trig_req_i   = '0;
    trig_mask_i  = '1;
    holdoff_i    = '0;
    event_done_i = 1'b0;
    curMask      = '1;
    n            = 0;
    modelReset();

    // Reset state, then release and run randomized traffic.
    @(negedge clk_i);
    checkAll();
    rst_i = 1'b0;
    applyRandom();
    for (int it = 0; it < 3000; it++) begin
      @(negedge clk_i);
      checkAll();
      if (it % 400 == 399) begin
        curMask = ($urandom_range(0, 1) == 0) ? '1 : NSRC'($urandom_range(1, 15));
      end
      applyRandom();
    end

    // Steer towards a holdoff window with events outstanding, then reset
    // asynchronously while source 2 is held high.
    curMask = '1;
    for (int k = 0; k < 300 && !((n < mReady) && !mEvent && (mPending > 0)); k++) begin
      @(negedge clk_i);
      checkAll();
      applyStimulus(trig_req_i ^ NSRC'($urandom_range(0, 15)), curMask, 1'b0, HW'(6));
    end
    @(negedge clk_i);
    checkAll();
    rst_i      = 1'b1;
    trig_req_i = 4'b0100;
    modelReset();
    #1;
    checkAll();
    repeat (2) begin
      @(negedge clk_i);
      checkAll();
    end
    @(negedge clk_i);
    checkAll();
    rst_i = 1'b0;
    applyStimulus(4'b0100, curMask, 1'b0, '0);
    @(negedge clk_i);
    checkAll();
    checkOutput("post_reset_event", {31'd0, event_o}, 32'd1);
    checkOutput("post_reset_info", event_info_o, {12'd0, 16'h0004, 4'd2});
    applyRandom();

    for (int it = 0; it < 3000; it++) begin
      @(negedge clk_i);
      checkAll();
      applyRandom();
    end

    checkOutput("events_seen_nonzero", {31'd0, (eventsSeen > 0)}, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
